// File: rtl/multi_phase_control.sv
// Five-phase fetch/decode/execute/memory/writeback sequencer.
// Outputs decode from the phase register and latched instruction word.
module multi_phase_control #(
    parameter int DATA_W     = 16,
    parameter int RA_W       = 3,
    parameter int IMM_SIGNED = 1
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              EXEC,
    input  logic [15:0]       COMMAND,
    input  logic [3:0]        SZCV,
    output logic [DATA_W-1:0] immediate,
    output logic [3:0]        S_ALU,
    output logic              AR_MUX,
    output logic              BR_MUX,
    output logic              INPUT_MUX,
    output logic              ADR_MUX,
    output logic [RA_W-1:0]   writeAddress,
    output logic              write,
    output logic              PC_load,
    output logic              PC_inc,
    output logic              IR_load,
    output logic              MEM_write,
    output logic              FLAG_load,
    output logic [2:0]        phase,
    output logic              running
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P1   = 3'd1,
        P2   = 3'd2,
        P3   = 3'd3,
        P4   = 3'd4,
        P5   = 3'd5
    } state_t;

    state_t      state, state_nx;
    logic [15:0] ir;
    logic        exec_q;
    logic        stop_q, stop_nx;
    logic        exec_rise;

    logic [3:0]  op;
    logic        is_alu, is_ld, is_st, is_li, is_b, is_bcc, is_halt;
    logic        taken;
    logic        in_dp;
    logic        unused_c;

    assign unused_c  = SZCV[1];
    assign exec_rise = EXEC & ~exec_q;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state  <= IDLE;
            ir     <= 16'h0000;
            exec_q <= 1'b0;
            stop_q <= 1'b0;
        end else begin
            state  <= state_nx;
            exec_q <= EXEC;
            stop_q <= stop_nx;
            if (state == P1) begin
                ir <= COMMAND;
            end
        end
    end

    // An edge that coincides with the return to IDLE is swallowed here.
    always_comb begin
        state_nx = IDLE;
        unique case (state)
            IDLE:    state_nx = exec_rise ? P1 : IDLE;
            P1:      state_nx = P2;
            P2:      state_nx = P3;
            P3:      state_nx = P4;
            P4:      state_nx = P5;
            P5:      state_nx = (stop_q || is_halt) ? IDLE : P1;
            default: state_nx = IDLE;
        endcase
        stop_nx = stop_q;
        if (state_nx == IDLE) begin
            stop_nx = 1'b0;
        end else if (exec_rise && state != IDLE) begin
            stop_nx = 1'b1;
        end
    end

    assign op      = ir[7:4];
    assign is_alu  = ir[15:14] == 2'b11;
    assign is_ld   = ir[15:14] == 2'b00;
    assign is_st   = ir[15:14] == 2'b01;
    assign is_li   = ir[15:11] == 5'b10000;
    assign is_b    = ir[15:11] == 5'b10100;
    assign is_bcc  = ir[15:11] == 5'b10111;
    assign is_halt = is_alu && op == 4'b1111;

    always_comb begin
        taken = 1'b0;
        case (ir[10:8])
            3'b000:  taken = SZCV[2];
            3'b001:  taken = SZCV[3] ^ SZCV[0];
            3'b010:  taken = SZCV[2] | (SZCV[3] ^ SZCV[0]);
            3'b011:  taken = ~SZCV[2];
            default: taken = 1'b0;
        endcase
    end

    assign in_dp = state == P2 || state == P3
                || state == P4 || state == P5;

    generate
        if (IMM_SIGNED != 0) begin : g_sext
            assign immediate = {{(DATA_W-8){ir[7]}}, ir[7:0]};
        end else begin : g_zext
            assign immediate = {{(DATA_W-8){1'b0}}, ir[7:0]};
        end
    endgenerate

    assign S_ALU        = is_alu ? op : 4'b1111;
    assign writeAddress = RA_W'(is_ld ? ir[13:11] : ir[10:8]);

    assign INPUT_MUX = in_dp && is_alu && op == 4'b1100;
    assign ADR_MUX   = in_dp && ((is_alu && op <= 4'b1011)
                     || ir[15:14] == 2'b10);
    assign BR_MUX    = in_dp && (ir[15:14] != 2'b10 || is_li);
    assign AR_MUX    = in_dp && is_alu && op <= 4'b0110;

    assign IR_load   = state == P1;
    assign FLAG_load = state == P3 && is_alu && op <= 4'b1011;
    assign MEM_write = state == P4 && is_st;
    assign write     = state == P5
                     && ((is_alu && op <= 4'b1100) || is_ld || is_li);
    assign PC_load   = state == P5 && (is_b || (is_bcc && taken));
    assign PC_inc    = state == P5 && !(is_b || (is_bcc && taken));

    assign phase   = state;
    assign running = state != IDLE;

endmodule
